ifmap_pingpong_input_controller: RTL and testbench

Ifmap input stage for the CNN accelerator. It serially accepts DATA_WIDTH-bit ifmap words and chains every IC0 consecutive words into one IC0-lane word. Chained words are written into the write bank of an internal ping-pong buffer while the PE array reads the other bank. The block runs a configurable number of bank fills (OY1*OX1 tiles), with backpressure and a bank-switch handshake; it generalises the single-tile, fixed-width controller.

---
 rtl/ifmap_pingpong_input_controller.sv | 207 ++++++++++++++++++++
 tb/tb_ifmap_pingpong_input_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_pingpong_input_controller.sv
// Ifmap ping-pong input controller.
// Serial DATA_WIDTH-bit ifmap words are chained IC0 at a time into one wide
// word and written into the write bank. The PE array reads the other bank.
// After each bank fill the block waits for a swap handshake, and it repeats
// this for the configured number of tiles.
// Optional build macro IFMAP_STALL_CNT_EN adds the stall_count output.
module ifmap_pingpong_input_controller #(
  parameter int DATA_WIDTH       = 16,
  parameter int IC0              = 2,
  parameter int BANK_ADDR_WIDTH  = 32,
  parameter int BUFFER_MEM_DEPTH = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           config_done,
  input  logic [BANK_ADDR_WIDTH-1:0]     config_IC1_IY0_IX0,
  input  logic [BANK_ADDR_WIDTH-1:0]     config_OY1_OX1,
  input  logic [DATA_WIDTH-1:0]          input_dat,
  input  logic                           input_vld,
  output logic                           input_rdy,
  input  logic                           ren,
  input  logic [BANK_ADDR_WIDTH-1:0]     raddr,
  output logic [DATA_WIDTH*IC0-1:0]      rdata,
  input  logic                           ready_to_switch,
  output logic                           write_bank_ready_to_switch,
  output logic [BANK_ADDR_WIDTH-1:0]     write_bank_count,
`ifdef IFMAP_STALL_CNT_EN
  output logic [BANK_ADDR_WIDTH-1:0]     stall_count,
`endif
  output logic                           all_banks_done
);

  localparam int WW  = DATA_WIDTH * IC0;
  localparam int MAW = (BUFFER_MEM_DEPTH > 1) ? $clog2(BUFFER_MEM_DEPTH) : 1;
  localparam int LCW = (IC0 > 1) ? $clog2(IC0) : 1;
  localparam logic [BANK_ADDR_WIDTH-1:0] ONE_W   = BANK_ADDR_WIDTH'(1);
  localparam logic [BANK_ADDR_WIDTH-1:0] DEPTH_W = BANK_ADDR_WIDTH'(BUFFER_MEM_DEPTH);
  localparam logic [LCW-1:0]             LAST_LANE = LCW'(IC0 - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                     state_r;
  logic [LCW-1:0]             lane_cnt_r;
  logic [DATA_WIDTH-1:0]      lane_r [IC0];
  logic [BANK_ADDR_WIDTH-1:0] waddr_r;
  logic                       wsel_r;
  logic [BANK_ADDR_WIDTH-1:0] cfg_words_r;
  logic [BANK_ADDR_WIDTH-1:0] cfg_tiles_r;
  logic [WW-1:0]              bank0_mem [BUFFER_MEM_DEPTH];
  logic [WW-1:0]              bank1_mem [BUFFER_MEM_DEPTH];

  logic          cfg_ok_s;
  logic          beat_s;
  logic          last_lane_s;
  logic          wr_en_s;
  logic          last_word_s;
  logic [WW-1:0] asm_word_s;

  assign cfg_ok_s    = (config_IC1_IY0_IX0 != {BANK_ADDR_WIDTH{1'b0}}) &&
                       (config_IC1_IY0_IX0 <= DEPTH_W) &&
                       (config_OY1_OX1 != {BANK_ADDR_WIDTH{1'b0}});
  assign beat_s      = input_vld && input_rdy && (state_r == ST_FILL);
  assign last_lane_s = (lane_cnt_r == LAST_LANE);
  assign wr_en_s     = beat_s && last_lane_s;
  assign last_word_s = (waddr_r == (cfg_words_r - ONE_W));

  // Assemble the chained word: stored lanes plus the current beat in the top lane.
  always_comb begin
    asm_word_s = {WW{1'b0}};
    for (int i = 0; i < IC0 - 1; i++) begin
      asm_word_s[i*DATA_WIDTH +: DATA_WIDTH] = lane_r[i];
    end
    asm_word_s[(IC0-1)*DATA_WIDTH +: DATA_WIDTH] = input_dat;
  end

  // Control FSM with registered handshake/status outputs and fill counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r                    <= ST_IDLE;
      input_rdy                  <= 1'b0;
      write_bank_ready_to_switch <= 1'b0;
      write_bank_count           <= {BANK_ADDR_WIDTH{1'b0}};
      all_banks_done             <= 1'b0;
      lane_cnt_r                 <= {LCW{1'b0}};
      waddr_r                    <= {BANK_ADDR_WIDTH{1'b0}};
      wsel_r                     <= 1'b0;
      cfg_words_r                <= {BANK_ADDR_WIDTH{1'b0}};
      cfg_tiles_r                <= {BANK_ADDR_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (config_done && cfg_ok_s) begin
            cfg_words_r <= config_IC1_IY0_IX0;
            cfg_tiles_r <= config_OY1_OX1;
            state_r     <= ST_FILL;
            input_rdy   <= 1'b1;
          end
        end
        ST_FILL: begin
          if (beat_s) begin
            if (last_lane_s) begin
              lane_cnt_r <= {LCW{1'b0}};
              if (last_word_s) begin
                waddr_r                    <= {BANK_ADDR_WIDTH{1'b0}};
                write_bank_count           <= write_bank_count + ONE_W;
                state_r                    <= ST_FULL;
                input_rdy                  <= 1'b0;
                write_bank_ready_to_switch <= 1'b1;
              end else begin
                waddr_r <= waddr_r + ONE_W;
              end
            end else begin
              lane_cnt_r <= lane_cnt_r + LCW'(1);
            end
          end
        end
        ST_FULL: begin
          if (ready_to_switch) begin
            wsel_r                     <= ~wsel_r;
            write_bank_ready_to_switch <= 1'b0;
            if (write_bank_count == cfg_tiles_r) begin
              state_r        <= ST_DONE;
              all_banks_done <= 1'b1;
            end else begin
              state_r   <= ST_FILL;
              input_rdy <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (config_done && cfg_ok_s) begin
            write_bank_count <= {BANK_ADDR_WIDTH{1'b0}};
            cfg_words_r      <= config_IC1_IY0_IX0;
            cfg_tiles_r      <= config_OY1_OX1;
            state_r          <= ST_FILL;
            input_rdy        <= 1'b1;
            all_banks_done   <= 1'b0;
          end
        end
        default: begin
          state_r                    <= ST_IDLE;
          input_rdy                  <= 1'b0;
          write_bank_ready_to_switch <= 1'b0;
          all_banks_done             <= 1'b0;
        end
      endcase
    end
  end

  // Capture the lower lanes of the chain; the top lane goes straight to the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IC0; i++) begin
        lane_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (beat_s && !last_lane_s) begin
      lane_r[lane_cnt_r] <= input_dat;
    end
  end

  // Bank write port; banks are not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      if (wsel_r) begin
        bank1_mem[waddr_r[MAW-1:0]] <= asm_word_s;
      end else begin
        bank0_mem[waddr_r[MAW-1:0]] <= asm_word_s;
      end
    end
  end

  // Registered read from the bank opposite the write bank; out of range reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= {WW{1'b0}};
    end else if (ren) begin
      if (raddr >= DEPTH_W) begin
        rdata <= {WW{1'b0}};
      end else if (wsel_r) begin
        rdata <= bank0_mem[raddr[MAW-1:0]];
      end else begin
        rdata <= bank1_mem[raddr[MAW-1:0]];
      end
    end
  end

`ifdef IFMAP_STALL_CNT_EN
  // Count cycles where input is offered but refused outside IDLE; saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= {BANK_ADDR_WIDTH{1'b0}};
    end else if (config_done && cfg_ok_s &&
                 ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
      stall_count <= {BANK_ADDR_WIDTH{1'b0}};
    end else if (input_vld && !input_rdy && (state_r != ST_IDLE) &&
                 (stall_count != {BANK_ADDR_WIDTH{1'b1}})) begin
      stall_count <= stall_count + ONE_W;
    end
  end
`endif

endmodule

// File: tb/tb_ifmap_pingpong_input_controller.sv
// Self-checking bench for ifmap_pingpong_input_controller (IC0=2, 16-bit lanes).
// Read responses are checked by a scoreboard monitor; status outputs are
// compared directly by the stimulus process.
module tb_ifmap_pingpong_input_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        config_done = 1'b0;
  logic [31:0] config_IC1_IY0_IX0 = 32'd0;
  logic [31:0] config_OY1_OX1 = 32'd0;
  logic [15:0] input_dat = 16'd0;
  logic        input_vld = 1'b0;
  logic        input_rdy;
  logic        ren = 1'b0;
  logic [31:0] raddr = 32'd0;
  logic [31:0] rdata;
  logic        ready_to_switch = 1'b0;
  logic        write_bank_ready_to_switch;
  logic [31:0] write_bank_count;
  logic        all_banks_done;
`ifdef IFMAP_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        ren_q;

  ifmap_pingpong_input_controller dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .config_done                (config_done),
    .config_IC1_IY0_IX0         (config_IC1_IY0_IX0),
    .config_OY1_OX1             (config_OY1_OX1),
    .input_dat                  (input_dat),
    .input_vld                  (input_vld),
    .input_rdy                  (input_rdy),
    .ren                        (ren),
    .raddr                      (raddr),
    .rdata                      (rdata),
    .ready_to_switch            (ready_to_switch),
    .write_bank_ready_to_switch (write_bank_ready_to_switch),
    .write_bank_count           (write_bank_count),
`ifdef IFMAP_STALL_CNT_EN
    .stall_count                (stall_count),
`endif
    .all_banks_done             (all_banks_done)
  );

  always #5 clk = ~clk;

  // Remember whether a read was issued at the last rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ren_q <= 1'b0;
    else        ren_q <= ren;
  end

  // Scoreboard monitor: one expected read word per issued read.
  always @(negedge clk) begin
    if (ren_q) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rdata_unexpected: got %h, required no read response", rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL rdata: got %h, required %h", rdata, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    config_done = 1'b0; input_vld = 1'b0; ren = 1'b0; ready_to_switch = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_config(input logic [31:0] words, input logic [31:0] tiles);
    config_IC1_IY0_IX0 = words; config_OY1_OX1 = tiles; config_done = 1'b1;
    tick();
    config_done = 1'b0;
  endtask

  // Offer one word and return after it has been accepted; input_vld stays high.
  task automatic send_word(input logic [15:0] d);
    int n;
    n = 0;
    input_vld = 1'b1; input_dat = d;
    while (!input_rdy && n < 50) begin tick(); n++; end
    checks++;
    if (!input_rdy) begin
      errors++;
      $display("FAIL send_timeout: got input_rdy=0, required 1 within 50 cycles");
    end
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    ren = 1'b1; raddr = a;
    tick();
    ren = 1'b0;
  endtask

  task automatic do_swap();
    ready_to_switch = 1'b1;
    tick();
    ready_to_switch = 1'b0;
  endtask

  function automatic logic [31:0] pk(input int hi, input int lo);
    return {16'(hi), 16'(lo)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    tick();
    check("rst_input_rdy", {31'd0, input_rdy}, 32'd0);
    check("rst_wbrts", {31'd0, write_bank_ready_to_switch}, 32'd0);
    check("rst_count", write_bank_count, 32'd0);
    check("rst_done", {31'd0, all_banks_done}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // ---- 1: single tile, 8 words ----
    do_config(32'd8, 32'd1);
    check("t1_rdy_fill", {31'd0, input_rdy}, 32'd1);
    for (int i = 1; i <= 16; i++) send_word(16'(i));
    input_vld = 1'b0;
    check("t1_wbrts", {31'd0, write_bank_ready_to_switch}, 32'd1);
    check("t1_count", write_bank_count, 32'd1);
    check("t1_rdy_full", {31'd0, input_rdy}, 32'd0);
    do_swap();
    check("t1_done", {31'd0, all_banks_done}, 32'd1);
    check("t1_wbrts_clr", {31'd0, write_bank_ready_to_switch}, 32'd0);
    for (int a = 0; a < 8; a++) do_read(32'(a), pk(2*a+2, 2*a+1));
    do_read(32'd300, 32'd0);
    do_read(32'd7, pk(16, 15));
    tick(); tick(); tick();
    check("t1_rdata_hold", rdata, pk(16, 15));

    // ---- 2: three tiles of 4 words, backpressure, bank alternation ----
    do_reset();
    do_config(32'd4, 32'd3);
    for (int j = 1; j <= 8; j++) send_word(16'(100 + j));
    input_dat = 16'd999;
    repeat (10) tick();
    check("t2_rdy_stalled", {31'd0, input_rdy}, 32'd0);
    check("t2_count_stalled", write_bank_count, 32'd1);
    check("t2_wbrts_stalled", {31'd0, write_bank_ready_to_switch}, 32'd1);
`ifdef IFMAP_STALL_CNT_EN
    check("t2_stall_count", stall_count, 32'd10);
`endif
    input_vld = 1'b0;
    do_swap();
    check("t2_rdy_tile2", {31'd0, input_rdy}, 32'd1);
    check("t2_done_low", {31'd0, all_banks_done}, 32'd0);
    for (int j = 1; j <= 4; j++) send_word(16'(200 + j));
    input_vld = 1'b0;
    for (int a = 0; a < 4; a++) do_read(32'(a), pk(100+2*a+2, 100+2*a+1));
    for (int j = 5; j <= 8; j++) send_word(16'(200 + j));
    input_vld = 1'b0;
    check("t2_count2", write_bank_count, 32'd2);
    do_swap();
    for (int a = 0; a < 4; a++) do_read(32'(a), pk(200+2*a+2, 200+2*a+1));
    for (int j = 1; j <= 8; j++) send_word(16'(300 + j));
    input_vld = 1'b0;
    check("t2_count3", write_bank_count, 32'd3);
    // Read on the same edge as the swap sees the pre-swap bank (tile 2).
    exp_q.push_back(pk(202, 201));
    ready_to_switch = 1'b1; ren = 1'b1; raddr = 32'd0;
    tick();
    ready_to_switch = 1'b0; ren = 1'b0;
    check("t2_done", {31'd0, all_banks_done}, 32'd1);
    do_read(32'd3, pk(308, 307));

    // ---- 3: bubbles between lanes ----
    do_reset();
    do_config(32'd2, 32'd1);
    send_word(16'h00a1); input_vld = 1'b0; tick(); tick(); tick();
    send_word(16'h00a2); input_vld = 1'b0;
    send_word(16'h00b1); input_vld = 1'b0; tick();
    send_word(16'h00b2); input_vld = 1'b0;
    check("t3_count", write_bank_count, 32'd1);
    do_swap();
    do_read(32'd0, 32'h00a2_00a1);
    do_read(32'd1, 32'h00b2_00b1);

    // ---- 4: rejected configs ----
    do_reset();
    do_config(32'd0, 32'd1);
    check("t4_words0", {31'd0, input_rdy}, 32'd0);
    do_config(32'd257, 32'd1);
    check("t4_words257", {31'd0, input_rdy}, 32'd0);
    do_config(32'd4, 32'd0);
    check("t4_tiles0", {31'd0, input_rdy}, 32'd0);
    do_config(32'd256, 32'd1);
    check("t4_accept256", {31'd0, input_rdy}, 32'd1);

    // ---- 5: reset mid-fill ----
    do_reset();
    do_config(32'd8, 32'd1);
    for (int j = 1; j <= 7; j++) send_word(16'(40 + j));
    input_vld = 1'b0;
    rst_n = 1'b0;
    tick();
    check("t5_rdy", {31'd0, input_rdy}, 32'd0);
    check("t5_count", write_bank_count, 32'd0);
    check("t5_wbrts", {31'd0, write_bank_ready_to_switch}, 32'd0);
    check("t5_done", {31'd0, all_banks_done}, 32'd0);
    rst_n = 1'b1;
    tick();
    do_config(32'd8, 32'd1);
    for (int j = 1; j <= 16; j++) send_word(16'(50 + j));
    input_vld = 1'b0;
    do_swap();
    check("t5_done_after", {31'd0, all_banks_done}, 32'd1);
    for (int a = 0; a < 8; a++) do_read(32'(a), pk(50+2*a+2, 50+2*a+1));

    tick(); tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
